// File: rtl/lcd1602_responder_if.sv
// Parallel HD44780-style LCD bus between an LCD driver (master) and the
// responder model (slave).
interface lcd1602_responder_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_db_in;
  logic [7:0] lcd_db_out;
  logic       lcd_db_oe;

  modport master (
    output lcd_rs, lcd_rw, lcd_en, lcd_db_in,
    input  lcd_db_out, lcd_db_oe
  );

  modport slave (
    input  lcd_rs, lcd_rw, lcd_en, lcd_db_in,
    output lcd_db_out, lcd_db_oe
  );
endinterface

// File: rtl/lcd1602_responder.sv
// HD44780-compatible LCD1602 responder: synchronizes the parallel bus, decodes
// commands/data into an 80-byte DDRAM and answers status/data reads.
module lcd1602_responder #(
  parameter int unsigned BUSY_CLEAR = 76000,
  parameter int unsigned BUSY_CMD   = 1850
) (
  input  logic               clk,
  input  logic               rst,
  lcd1602_responder_if.slave lcd,
  input  logic [6:0]         rd_addr,
  output logic [7:0]         rd_data,
  output logic               busy,
  output logic               disp_on,
  output logic               cursor_on,
  output logic               blink_on,
  output logic               two_line,
  output logic               overrun
);

  localparam int unsigned BMAX0 = (BUSY_CLEAR > BUSY_CMD) ? BUSY_CLEAR : BUSY_CMD;
  localparam int unsigned BMAX  = (BMAX0 > 80) ? BMAX0 : 80;
  localparam int unsigned CW    = $clog2(BMAX + 1);

  localparam logic [CW-1:0] C_CLEAR = CW'(BUSY_CLEAR);
  localparam logic [CW-1:0] C_CMD   = CW'(BUSY_CMD);
  localparam logic [CW-1:0] C_FILL  = CW'(80);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic {ST_IDLE, ST_FILL} state_t;

  logic          r_en_s1, r_en_s2, r_en_d;
  logic          r_rs_s1, r_rs_s2;
  logic          r_rw_s1, r_rw_s2;
  logic [7:0]    r_db_s1, r_db_s2;
  logic          r_hold_rs, r_hold_rw;
  logic [7:0]    r_hold_db;
  logic          r_fire;

  logic [6:0]    r_ac;
  logic          r_id;
  logic          r_s_unused;
  logic          r_disp, r_cur, r_blink, r_two;
  logic [CW-1:0] r_cnt;
  logic          r_ovr;

  state_t        r_state, w_state_next;
  logic [6:0]    r_fill_idx;

  logic [7:0]    r_mem [0:79];
  logic [7:0]    r_rd_data;
  logic [7:0]    r_db_out;
  logic          r_db_oe;

  logic          w_fall;
  logic          w_busy;
  logic [6:0]    w_ac_idx;
  logic          w_wr_accept;
  logic          w_data_wr;
  logic          w_clear;
  logic          w_mem_we;
  logic [6:0]    w_mem_idx;
  logic [7:0]    w_mem_wd;

  // Address counter step with the two-line wrap: 0x27<->0x40, 0x67<->0x00.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] n;
    if (inc) begin
      if (ac == 7'h27)      n = 7'h40;
      else if (ac == 7'h67) n = 7'h00;
      else                  n = ac + 7'd1;
    end else begin
      if (ac == 7'h00)      n = 7'h67;
      else if (ac == 7'h40) n = 7'h27;
      else                  n = ac - 7'd1;
    end
    return n;
  endfunction

  function automatic logic [6:0] ac_to_idx(input logic [6:0] ac);
    return ac[6] ? (ac - 7'd24) : ac;
  endfunction

  function automatic logic ac_valid(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  // Bus synchronizers, enable edge detect and transaction hold register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_s1   <= 1'b0;
      r_en_s2   <= 1'b0;
      r_en_d    <= 1'b0;
      r_rs_s1   <= 1'b0;
      r_rs_s2   <= 1'b0;
      r_rw_s1   <= 1'b0;
      r_rw_s2   <= 1'b0;
      r_db_s1   <= '0;
      r_db_s2   <= '0;
      r_hold_rs <= 1'b0;
      r_hold_rw <= 1'b0;
      r_hold_db <= '0;
      r_fire    <= 1'b0;
    end else begin
      r_en_s1 <= lcd.lcd_en;
      r_en_s2 <= r_en_s1;
      r_en_d  <= r_en_s2;
      r_rs_s1 <= lcd.lcd_rs;
      r_rs_s2 <= r_rs_s1;
      r_rw_s1 <= lcd.lcd_rw;
      r_rw_s2 <= r_rw_s1;
      r_db_s1 <= lcd.lcd_db_in;
      r_db_s2 <= r_db_s1;
      if (r_en_s2) begin
        r_hold_rs <= r_rs_s2;
        r_hold_rw <= r_rw_s2;
        r_hold_db <= r_db_s2;
      end
      r_fire <= w_fall;
    end
  end

  assign w_fall      = r_en_d & ~r_en_s2;
  assign w_busy      = (r_cnt != '0) || (r_state == ST_FILL);
  assign w_ac_idx    = ac_to_idx(r_ac);
  assign w_wr_accept = r_fire & ~r_hold_rw & ~w_busy;
  assign w_data_wr   = w_wr_accept & r_hold_rs;
  assign w_clear     = w_wr_accept & ~r_hold_rs & (r_hold_db == 8'h01);

  // Command/data decode, address counter, busy counter and control state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ac       <= '0;
      r_id       <= 1'b1;
      r_s_unused <= 1'b0;
      r_disp     <= 1'b0;
      r_cur      <= 1'b0;
      r_blink    <= 1'b0;
      r_two      <= 1'b0;
      r_cnt      <= C_FILL;
      r_ovr      <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (r_cnt != '0) r_cnt <= r_cnt - C_ONE;
      if (r_fire) begin
        if (r_hold_rw) begin
          if (r_hold_rs) r_ac <= ac_step(r_ac, r_id);
        end else if (w_busy) begin
          r_ovr <= 1'b1;
        end else if (r_hold_rs) begin
          r_ac  <= ac_step(r_ac, r_id);
          r_cnt <= C_CMD;
        end else begin
          casez (r_hold_db)
            8'b1???????: begin
              r_ac  <= ac_valid(r_hold_db[6:0]) ? r_hold_db[6:0] : 7'h00;
              r_cnt <= C_CMD;
            end
            8'b01??????: r_cnt <= C_CMD;
            8'b001?????: begin
              r_two <= r_hold_db[3];
              r_cnt <= C_CMD;
            end
            8'b0001????: begin
              if (!r_hold_db[3]) r_ac <= ac_step(r_ac, r_hold_db[2]);
              r_cnt <= C_CMD;
            end
            8'b00001???: begin
              r_disp  <= r_hold_db[2];
              r_cur   <= r_hold_db[1];
              r_blink <= r_hold_db[0];
              r_cnt   <= C_CMD;
            end
            8'b000001??: begin
              r_id       <= r_hold_db[1];
              r_s_unused <= r_hold_db[0];
              r_cnt      <= C_CMD;
            end
            8'b0000001?: begin
              r_ac  <= 7'h00;
              r_cnt <= C_CLEAR;
            end
            8'b00000001: begin
              r_ac  <= 7'h00;
              r_id  <= 1'b1;
              r_cnt <= C_CLEAR;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Clear-fill sequencer: writes 0x20 to one DDRAM index per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FILL;
      r_fill_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_clear)                  r_fill_idx <= '0;
      else if (r_state == ST_FILL)  r_fill_idx <= r_fill_idx + 7'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_clear) w_state_next = ST_FILL;
      ST_FILL: if (r_fill_idx == 7'd79) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A bus write can never coincide with the fill: busy drops it first.
  always_comb begin
    w_mem_we  = 1'b0;
    w_mem_idx = w_ac_idx;
    w_mem_wd  = r_hold_db;
    if (!rst) begin
      if (r_state == ST_FILL) begin
        w_mem_we  = 1'b1;
        w_mem_idx = r_fill_idx;
        w_mem_wd  = 8'h20;
      end else if (w_data_wr) begin
        w_mem_we  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= 8'h20;
    end else if (rd_addr < 7'd80) begin
      r_rd_data <= r_mem[rd_addr];
    end else begin
      r_rd_data <= 8'h20;
    end
  end

  // Read data follows the synchronized strobe, not the hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_oe  <= 1'b0;
      r_db_out <= '0;
    end else begin
      r_db_oe <= r_en_s2 & r_rw_s2;
      if (r_en_s2 & r_rw_s2) r_db_out <= r_rs_s2 ? r_mem[w_ac_idx] : {w_busy, r_ac};
      else                   r_db_out <= '0;
    end
  end

  assign lcd.lcd_db_out = r_db_out;
  assign lcd.lcd_db_oe  = r_db_oe;
  assign rd_data        = r_rd_data;
  assign busy           = w_busy;
  assign disp_on        = r_disp;
  assign cursor_on      = r_cur;
  assign blink_on       = r_blink;
  assign two_line       = r_two;
  assign overrun        = r_ovr;

endmodule

// File: tb/tb_lcd1602_responder.sv
// Scoreboard bench for lcd1602_responder driving the LCD bus as a master.
module tb_lcd1602_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lcd1602_responder_if bus();
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic busy, disp_on, cursor_on, blink_on, two_line, overrun;

  lcd1602_responder #(.BUSY_CLEAR(100), .BUSY_CMD(10)) dut (
    .clk(clk), .rst(rst), .lcd(bus), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .overrun(overrun)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int run_len = 0, last_run = 0, ovr_cnt = 0;

  always @(negedge clk) begin
    if (busy === 1'b1) run_len++;
    else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
    if (overrun === 1'b1) ovr_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic bus_write(input logic rs, input logic [7:0] db);
    @(negedge clk);
    bus.lcd_rs = rs; bus.lcd_rw = 1'b0; bus.lcd_db_in = db;
    repeat (3) @(negedge clk);
    bus.lcd_en = 1'b1;
    repeat (5) @(negedge clk);
    bus.lcd_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) begin
      n_vec++; n_err++;
      $display("FAIL wait_idle: busy=%b, required 0 within 500 cycles", busy);
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic rs, input logic [7:0] db);
    bus_write(rs, db);
    wait_idle();
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] got,
                          output logic oe_hold, output logic oe_drop);
    @(negedge clk);
    bus.lcd_rs = rs; bus.lcd_rw = 1'b1;
    repeat (3) @(negedge clk);
    bus.lcd_en = 1'b1;
    got = 'x;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.lcd_db_oe === 1'b1) begin got = bus.lcd_db_out; break; end
    end
    repeat (3) @(negedge clk);
    bus.lcd_en = 1'b0;
    repeat (2) @(negedge clk);
    oe_hold = (bus.lcd_db_oe === 1'b1);
    @(negedge clk);
    oe_drop = (bus.lcd_db_oe === 1'b0);
    repeat (2) @(negedge clk);
    bus.lcd_rw = 1'b0;
  endtask

  task automatic mirror_read(input logic [6:0] idx, output logic [7:0] got);
    @(negedge clk);
    rd_addr = idx;
    @(negedge clk);
    got = rd_data;
  endtask

  task automatic chk_status(input string name, input logic [7:0] e);
    logic [7:0] got, x; logic h, d;
    exp_q.push_back(e);
    bus_read(1'b0, got, h, d);
    x = exp_q.pop_front();
    n_vec++;
    if (got !== x) begin n_err++; $display("FAIL %s: status %02h, required %02h", name, got, x); end
  endtask

  task automatic chk_mirror(input string name, input logic [6:0] idx, input logic [7:0] e);
    logic [7:0] got, x;
    exp_q.push_back(e);
    mirror_read(idx, got);
    x = exp_q.pop_front();
    n_vec++;
    if (got !== x) begin n_err++; $display("FAIL %s: rd_data[%0d]=%02h, required %02h", name, idx, got, x); end
  endtask

  task automatic test_reset();
    int cnt = 0;
    rst = 1'b1; rd_addr = '0;
    bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_db_in = '0;
    repeat (4) @(negedge clk);
    n_vec++;
    if ({disp_on, cursor_on, blink_on, two_line, overrun, bus.lcd_db_oe} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: %b, required 000000",
               {disp_on, cursor_on, blink_on, two_line, overrun, bus.lcd_db_oe});
    end
    n_vec++;
    if ({rd_data, bus.lcd_db_out} !== 16'h2000) begin
      n_err++; $display("FAIL reset_data: rd_data/db_out %04h, required 2000", {rd_data, bus.lcd_db_out});
    end
    rst = 1'b0;
    while (busy === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
    n_vec++;
    if (cnt != 80) begin n_err++; $display("FAIL reset_busy_len: %0d, required 80", cnt); end
    chk_mirror("reset_fill0", 7'd0, 8'h20);
    chk_mirror("reset_fill39", 7'd39, 8'h20);
    chk_mirror("reset_fill79", 7'd79, 8'h20);
    chk_status("reset_status", 8'h00);
  endtask

  task automatic test_init();
    wr(1'b0, 8'h38);
    n_vec++;
    if (last_run != 10) begin n_err++; $display("FAIL cmd_busy_len: %0d, required 10", last_run); end
    wr(1'b0, 8'h0C);
    wr(1'b0, 8'h06);
    wr(1'b0, 8'h01);
    n_vec++;
    if (last_run != 100) begin n_err++; $display("FAIL clear_busy_len: %0d, required 100", last_run); end
    wr(1'b0, 8'h80);
    wr(1'b1, 8'h4F);
    n_vec++;
    if ({two_line, disp_on, cursor_on, blink_on} !== 4'b1100) begin
      n_err++; $display("FAIL init_ctrl: %b, required 1100", {two_line, disp_on, cursor_on, blink_on});
    end
    chk_mirror("init_data", 7'd0, 8'h4F);
    chk_status("init_ac", 8'h01);
  endtask

  task automatic test_wrap();
    wr(1'b0, 8'hA7);
    wr(1'b1, 8'h41);
    wr(1'b1, 8'h42);
    chk_mirror("wrap_39", 7'd39, 8'h41);
    chk_mirror("wrap_40", 7'd40, 8'h42);
    chk_status("wrap_ac", 8'h41);
  endtask

  task automatic test_overrun();
    int o0 = ovr_cnt;
    bus_write(1'b0, 8'h01);
    chk_status("status_busy", 8'h80);
    bus_write(1'b1, 8'h55);
    wait_idle();
    n_vec++;
    if (ovr_cnt - o0 != 1) begin n_err++; $display("FAIL overrun_pulses: %0d, required 1", ovr_cnt - o0); end
    n_vec++;
    if (last_run != 100) begin n_err++; $display("FAIL overrun_busy_len: %0d, required 100", last_run); end
    chk_status("overrun_ac", 8'h00);
    chk_mirror("overrun_mem", 7'd0, 8'h20);
  endtask

  task automatic test_entry_dec();
    wr(1'b0, 8'h04);
    wr(1'b0, 8'h80);
    wr(1'b1, 8'h58);
    chk_mirror("dec_data", 7'd0, 8'h58);
    chk_status("dec_wrap_ac", 8'h67);
  endtask

  task automatic test_data_read();
    logic [7:0] got, x; logic h, d;
    wr(1'b0, 8'h06);
    wr(1'b0, 8'h85);
    wr(1'b1, 8'hA5);
    wr(1'b1, 8'h5A);
    wr(1'b0, 8'h85);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 2; i++) begin
      bus_read(1'b1, got, h, d);
      x = exp_q.pop_front();
      n_vec++;
      if (got !== x) begin n_err++; $display("FAIL data_read%0d: %02h, required %02h", i, got, x); end
      n_vec++;
      if ({h, d} !== 2'b11) begin
        n_err++; $display("FAIL oe_timing%0d: hold/drop %b, required 11", i, {h, d});
      end
    end
    chk_status("read_ac", 8'h07);
  endtask

  task automatic test_boundary();
    wr(1'b0, 8'hC0);
    wr(1'b0, 8'h10);
    chk_status("shift_left_wrap", 8'h27);
    wr(1'b0, 8'h14);
    chk_status("shift_right_wrap", 8'h40);
    wr(1'b0, 8'hB0);
    chk_status("coerce_30", 8'h00);
    wr(1'b0, 8'h85);
    wr(1'b0, 8'hE8);
    chk_status("coerce_68", 8'h00);
    wr(1'b0, 8'hE7);
    wr(1'b1, 8'h77);
    chk_mirror("last_idx", 7'd79, 8'h77);
    chk_status("inc_wrap_67", 8'h00);
    wr(1'b0, 8'h0F);
    n_vec++;
    if ({disp_on, cursor_on, blink_on} !== 3'b111) begin
      n_err++; $display("FAIL disp_ctrl: %b, required 111", {disp_on, cursor_on, blink_on});
    end
    chk_mirror("mirror_oob", 7'd100, 8'h20);
  endtask

  initial begin
    test_reset();
    test_init();
    test_wrap();
    test_overrun();
    test_entry_dec();
    test_data_read();
    test_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
